// File: rtl/and_gate_pkg.sv
// and_gate_pkg: shared defaults and helpers for the AND gate primitive.
// Provides width defaults and the saturating counter increment.
package and_gate_pkg;

  localparam int AND_WIDTH_DEF = 1;
  localparam int AND_CNT_W_DEF = 16;

  // Increment cnt unless it already equals max (no wrap).
  function automatic logic [63:0] sat_inc(
    input logic [63:0] cnt,
    input logic [63:0] max
  );
    return (cnt == max) ? cnt : cnt + 64'd1;
  endfunction

endpackage

// File: rtl/and_gate_if.sv
// and_gate_if: bundle of the AND gate operand and observation signals.
// master drives in_a/in_b; slave drives out_, out_q, rise, hi_count
// (and out_n when AND_GATE_NAND_EN is defined).
interface and_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);

  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] out_;
  logic [WIDTH-1:0] out_q;
  logic             rise;
  logic [CNT_W-1:0] hi_count;
`ifdef AND_GATE_NAND_EN
  logic [WIDTH-1:0] out_n;
`endif

  modport master (
`ifdef AND_GATE_NAND_EN
    input  out_n,
`endif
    output in_a,
    output in_b,
    input  out_,
    input  out_q,
    input  rise,
    input  hi_count
  );

  modport slave (
`ifdef AND_GATE_NAND_EN
    output out_n,
`endif
    input  in_a,
    input  in_b,
    output out_,
    output out_q,
    output rise,
    output hi_count
  );

endinterface

// File: rtl/and_gate_cell.sv
// and_gate_cell: single-bit AND primitive.
// Ports: a, b operands; y = a & b.
module and_gate_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/and_gate.sv
// and_gate: WIDTH-bit AND with a clocked observation stage.
// Ports: out_ = in_a & in_b (comb); clk, rst (sync, active-high);
// out_q = out_ delayed 1 cycle; rise = 1-cycle pulse on &out_ 0->1;
// hi_count = saturating count of cycles with &out_ = 1.
// Macro AND_GATE_NAND_EN adds out_n = ~out_ (comb).
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH = AND_WIDTH_DEF,
  parameter int CNT_W = AND_CNT_W_DEF
) (
  output logic [WIDTH-1:0] out_,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic             rise,
  output logic [CNT_W-1:0] hi_count
`ifdef AND_GATE_NAND_EN
  ,
  output logic [WIDTH-1:0] out_n
`endif
);

  localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

  logic all_hi;
  logic prev_hi;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    and_gate_cell u_cell (
      .a (in_a[i]),
      .b (in_b[i]),
      .y (out_[i])
    );
  end

  assign all_hi = &out_;

`ifdef AND_GATE_NAND_EN
  assign out_n = ~out_;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      rise     <= 1'b0;
      prev_hi  <= 1'b0;
      hi_count <= '0;
    end else begin
      out_q   <= out_;
      rise    <= all_hi & ~prev_hi;
      prev_hi <= all_hi;
      if (all_hi)
        hi_count <= CNT_W'(sat_inc(64'(hi_count), CNT_MAX));
    end
  end

endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed checks of and_gate at WIDTH=1, WIDTH=4
// and CNT_W=3 (saturation), plus out_n when AND_GATE_NAND_EN is set.
module tb_and_gate;

  logic clk;
  logic clk_en;
  logic rst;

  int checks;
  int failures;

  and_gate_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  and_gate_if #(.WIDTH(4), .CNT_W(16)) if4 ();
  and_gate_if #(.WIDTH(1), .CNT_W(3))  if3 ();

  and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .out_     (if1.out_),
    .in_a     (if1.in_a),
    .in_b     (if1.in_b),
    .clk      (clk),
    .rst      (rst),
    .out_q    (if1.out_q),
    .rise     (if1.rise),
    .hi_count (if1.hi_count)
`ifdef AND_GATE_NAND_EN
    ,
    .out_n    (if1.out_n)
`endif
  );

  and_gate #(.WIDTH(4), .CNT_W(16)) u4 (
    .out_     (if4.out_),
    .in_a     (if4.in_a),
    .in_b     (if4.in_b),
    .clk      (clk),
    .rst      (rst),
    .out_q    (if4.out_q),
    .rise     (if4.rise),
    .hi_count (if4.hi_count)
`ifdef AND_GATE_NAND_EN
    ,
    .out_n    (if4.out_n)
`endif
  );

  and_gate #(.WIDTH(1), .CNT_W(3)) u3 (
    .out_     (if3.out_),
    .in_a     (if3.in_a),
    .in_b     (if3.in_b),
    .clk      (clk),
    .rst      (rst),
    .out_q    (if3.out_q),
    .rise     (if3.rise),
    .hi_count (if3.hi_count)
`ifdef AND_GATE_NAND_EN
    ,
    .out_n    (if3.out_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  typedef struct {
    logic a;
    logic b;
    logic y;
  } vec1_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
  } vec4_t;

  vec1_t tt1[4];
  vec4_t tt4[4];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    if1.in_a = 1'b0;
    if1.in_b = 1'b0;
    if3.in_a = 1'b0;
    if3.in_b = 1'b0;
    if4.in_a = 4'b0;
    if4.in_b = 4'b0;

    tt1[0] = '{1'b0, 1'b0, 1'b0};
    tt1[1] = '{1'b0, 1'b1, 1'b0};
    tt1[2] = '{1'b1, 1'b0, 1'b0};
    tt1[3] = '{1'b1, 1'b1, 1'b1};

    tt4[0] = '{4'b1100, 4'b1010, 4'b1000};
    tt4[1] = '{4'b1111, 4'b1111, 4'b1111};
    tt4[2] = '{4'b0000, 4'b1111, 4'b0000};
    tt4[3] = '{4'b0110, 4'b0011, 4'b0010};

    // Combinational truth table, clock stopped.
    for (int i = 0; i < 4; i++) begin
      if1.in_a = tt1[i].a;
      if1.in_b = tt1[i].b;
      #10;
      chk($sformatf("tt1_out[%0d]", i), 32'(if1.out_), 32'(tt1[i].y));
`ifdef AND_GATE_NAND_EN
      chk($sformatf("tt1_out_n[%0d]", i), 32'(if1.out_n), 32'(~tt1[i].y));
`endif
    end

    for (int i = 0; i < 4; i++) begin
      if4.in_a = tt4[i].a;
      if4.in_b = tt4[i].b;
      #10;
      chk($sformatf("tt4_out[%0d]", i), 32'(if4.out_), 32'(tt4[i].y));
    end

    // Reset for 2 cycles with inputs high.
    if1.in_a = 1'b1;
    if1.in_b = 1'b1;
    if4.in_a = 4'b1100;
    if4.in_b = 4'b1010;
    clk_en   = 1'b1;
    tick();
    tick();
    chk("rst_out_q",    32'(if1.out_q),    32'd0);
    chk("rst_rise",     32'(if1.rise),     32'd0);
    chk("rst_hi_count", 32'(if1.hi_count), 32'd0);
    chk("rst_out_q4",   32'(if4.out_q),    32'd0);
    chk("rst_out_comb", 32'(if1.out_),     32'd1);

    // Release and hold high for 5 cycles.
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("hold_rise[%0d]", i), 32'(if1.rise), (i == 1) ? 32'd1 : 32'd0);
      chk($sformatf("hold_cnt[%0d]", i), 32'(if1.hi_count), 32'(i));
      chk($sformatf("hold_q[%0d]", i), 32'(if1.out_q), 32'd1);
    end
    chk("w4_out_q", 32'(if4.out_q), 32'b1000);
    chk("w4_rise",  32'(if4.rise),  32'd0);
    chk("w4_cnt",   32'(if4.hi_count), 32'd0);

    // Drop b: count holds, no pulse.
    if1.in_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("drop_cnt[%0d]", i), 32'(if1.hi_count), 32'd5);
      chk($sformatf("drop_rise[%0d]", i), 32'(if1.rise), 32'd0);
      chk($sformatf("drop_q[%0d]", i), 32'(if1.out_q), 32'd0);
    end

    // Reassert high, then reset mid-operation.
    if1.in_b = 1'b1;
    tick();
    chk("re_rise", 32'(if1.rise), 32'd1);
    chk("re_cnt",  32'(if1.hi_count), 32'd6);
    rst = 1'b1;
    tick();
    chk("mid_rst_rise", 32'(if1.rise), 32'd0);
    chk("mid_rst_cnt",  32'(if1.hi_count), 32'd0);
    chk("mid_rst_q",    32'(if1.out_q), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_rise", 32'(if1.rise), 32'd1);
    chk("post_rst_cnt",  32'(if1.hi_count), 32'd1);

    // Saturation with CNT_W=3.
    if3.in_a = 1'b1;
    if3.in_b = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("sat_cnt[%0d]", i), 32'(if3.hi_count), (i > 7) ? 32'd7 : 32'(i));
      chk($sformatf("sat_rise[%0d]", i), 32'(if3.rise), (i == 1) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
